ifu_fetch_ysyx: RTL and testbench

Instruction fetch stage sitting directly upstream of the decoder.
- Holds the architectural PC and issues one read per instruction to instruction memory over an AXI-lite-style AR/R channel pair.
- Hands the returned 32-bit word plus its PC to the decode stage with a valid/ready handshake.
- Waits for the backend to return the next PC before starting the next fetch: single-issue, one instruction in flight.

---
 rtl/ifu_fetch_ysyx.sv | 155 +++++++++++++++
 tb/tb_ifu_fetch_ysyx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ysyx.sv
// ifu_fetch_ysyx: single-issue instruction fetch stage.
// Sends one AR/R read per instruction, hands {inst, pc, err} to decode over a
// valid/ready handshake, then waits for the backend's next PC before fetching again.
// Optional macro IFU_PERF_EN enables the fetch/stall performance counters; when it is
// not defined, perf_fetch_cnt and perf_stall_cnt are tied to zero.
module ifu_fetch_ysyx #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_RESP  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_err;
    // Registered copy of rst: masks the handshake outputs while reset is held
    // without creating a combinational path from the rst pin to arvalid/inst_valid.
    logic              r_rst_q;

    logic              w_arvalid;
    logic              w_rready;
    logic              w_inst_valid;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_issue_hs;
    logic              w_pc_load;

    // Remember whether the previous edge saw reset asserted.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    // State register plus the PC and latched-instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0;
            r_inst_pc <= RESET_PC;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_load) begin
                r_pc <= npc;
            end
            if (w_r_hs) begin
                r_inst    <= rdata;
                r_err     <= (rresp != 2'b00);
                r_inst_pc <= r_pc;
            end
        end
    end

    // Next-state logic and handshake outputs, decoded from state only.
    always_comb begin
        w_state_nxt  = r_state;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_inst_valid = 1'b0;
        w_pc_load    = 1'b0;
        case (r_state)
            S_FETCH: w_arvalid    = ~r_rst_q;
            S_RESP:  w_rready     = ~r_rst_q;
            S_ISSUE: w_inst_valid = ~r_rst_q;
            default: ;
        endcase
        w_ar_hs    = w_arvalid & arready;
        w_r_hs     = w_rready & rvalid;
        w_issue_hs = w_inst_valid & inst_ready;
        case (r_state)
            S_FETCH: if (w_ar_hs) w_state_nxt = S_RESP;
            S_RESP:  if (w_r_hs)  w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_issue_hs) begin
                    if (npc_valid) begin
                        // Single-cycle backend: skip S_WAIT entirely.
                        w_pc_load   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (npc_valid) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    assign arvalid    = w_arvalid;
    assign araddr     = r_pc;
    assign rready     = w_rready;
    assign inst_valid = w_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_err   = r_err;

`ifdef IFU_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Retired-fetch and front-end stall counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_issue_hs) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (((r_state == S_FETCH) || (r_state == S_RESP)) && !r_rst_q) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_fetch_ysyx.sv
// Testbench for ifu_fetch_ysyx: cycle-by-cycle vector table plus a hand-written
// back-to-back fetch sequence with a bounded wait.
module tb_ifu_fetch_ysyx;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ifu_fetch_ysyx #(.ADDR_W(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_err(inst_err),
        .npc_valid(npc_valid), .npc(npc),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        inst_ready;
        logic        npc_valid;
        logic [31:0] npc;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic        e_rready;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ar, input logic rv, input logic [31:0] rd,
                       input logic [1:0] rs, input logic ir, input logic nv, input logic [31:0] np,
                       input logic eav, input logic [31:0] ead, input logic err_, input logic eiv,
                       input logic [31:0] ein, input logic [31:0] epc, input logic eer);
        vec_t v;
        v.rst = r; v.arready = ar; v.rvalid = rv; v.rdata = rd; v.rresp = rs;
        v.inst_ready = ir; v.npc_valid = nv; v.npc = np;
        v.e_arvalid = eav; v.e_araddr = ead; v.e_rready = err_; v.e_iv = eiv;
        v.e_inst = ein; v.e_pc = epc; v.e_err = eer;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        int cycles;
        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;

        //   rst ar rv rdata         rr     ir nv npc            | av addr          rr iv inst          pc            err
        add(1, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 0, 32'h0,        32'h8000_0000, 0); // 0 reset
        add(1, 1, 1, 32'h1111_1111,2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 0, 32'h0,        32'h8000_0000, 0); // 1 reset held, outputs masked
        add(0, 1, 0, 32'h0,        2'b00, 0, 0, 32'h0,          1, 32'h8000_0000, 0, 0, 32'h0,        32'h8000_0000, 0); // 2 release -> AR
        add(0, 1, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 1, 0, 32'h0,        32'h8000_0000, 0); // 3 AR hs -> RESP
        add(0, 0, 1, 32'h0000_0413,2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 1, 32'h0000_0413,32'h8000_0000, 0); // 4 R hs -> ISSUE
        add(0, 0, 0, 32'h0,        2'b00, 0, 1, 32'hDEAD_0000,  0, 32'h8000_0000, 0, 1, 32'h0000_0413,32'h8000_0000, 0); // 5 held, npc ignored
        add(0, 0, 0, 32'h0,        2'b00, 1, 0, 32'h0,          0, 32'h8000_0000, 0, 0, 32'h0000_0413,32'h8000_0000, 0); // 6 accepted -> WAIT
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 0, 32'h0000_0413,32'h8000_0000, 0); // 7 WAIT
        add(0, 0, 0, 32'h0,        2'b00, 0, 1, 32'h8000_0004,  1, 32'h8000_0004, 0, 0, 32'h0000_0413,32'h8000_0000, 0); // 8 npc -> FETCH
        add(0, 1, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0004, 1, 0, 32'h0000_0413,32'h8000_0000, 0); // 9 RESP
        add(0, 0, 1, 32'h0010_0093,2'b00, 0, 0, 32'h0,          0, 32'h8000_0004, 0, 1, 32'h0010_0093,32'h8000_0004, 0); // 10 ISSUE
        add(0, 0, 0, 32'h0,        2'b00, 1, 1, 32'h8000_0100,  1, 32'h8000_0100, 0, 0, 32'h0010_0093,32'h8000_0004, 0); // 11 jal, no WAIT
        add(0, 0, 1, 32'h0,        2'b00, 0, 1, 32'h1234_5678,  1, 32'h8000_0100, 0, 0, 32'h0010_0093,32'h8000_0004, 0); // 12 stall, npc/rvalid ignored
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          1, 32'h8000_0100, 0, 0, 32'h0010_0093,32'h8000_0004, 0); // 13
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          1, 32'h8000_0100, 0, 0, 32'h0010_0093,32'h8000_0004, 0); // 14
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          1, 32'h8000_0100, 0, 0, 32'h0010_0093,32'h8000_0004, 0); // 15
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          1, 32'h8000_0100, 0, 0, 32'h0010_0093,32'h8000_0004, 0); // 16
        add(0, 1, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0100, 1, 0, 32'h0010_0093,32'h8000_0004, 0); // 17 AR hs
        add(0, 0, 0, 32'h0,        2'b00, 0, 1, 32'h5555_0000,  0, 32'h8000_0100, 1, 0, 32'h0010_0093,32'h8000_0004, 0); // 18 RESP, npc ignored
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0100, 1, 0, 32'h0010_0093,32'h8000_0004, 0); // 19
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0100, 1, 0, 32'h0010_0093,32'h8000_0004, 0); // 20
        add(0, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0100, 1, 0, 32'h0010_0093,32'h8000_0004, 0); // 21
        add(0, 0, 1, 32'hDEAD_BEEF,2'b10, 0, 0, 32'h0,          0, 32'h8000_0100, 0, 1, 32'hDEAD_BEEF,32'h8000_0100, 1); // 22 SLVERR
        add(0, 0, 0, 32'h0,        2'b00, 1, 0, 32'h0,          0, 32'h8000_0100, 0, 0, 32'hDEAD_BEEF,32'h8000_0100, 1); // 23 WAIT, err held
        add(0, 0, 0, 32'h0,        2'b00, 0, 1, 32'h8000_0104,  1, 32'h8000_0104, 0, 0, 32'hDEAD_BEEF,32'h8000_0100, 1); // 24
        add(0, 1, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0104, 1, 0, 32'hDEAD_BEEF,32'h8000_0100, 1); // 25
        add(0, 0, 1, 32'h0000_0013,2'b00, 0, 0, 32'h0,          0, 32'h8000_0104, 0, 1, 32'h0000_0013,32'h8000_0104, 0); // 26 err clears
        add(0, 0, 0, 32'h0,        2'b00, 1, 1, 32'h8000_0108,  1, 32'h8000_0108, 0, 0, 32'h0000_0013,32'h8000_0104, 0); // 27
        add(0, 1, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0108, 1, 0, 32'h0000_0013,32'h8000_0104, 0); // 28 RESP outstanding
        add(1, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 0, 32'h0,        32'h8000_0000, 0); // 29 reset mid-read
        add(0, 0, 1, 32'h7777_7777,2'b00, 0, 0, 32'h0,          1, 32'h8000_0000, 0, 0, 32'h0,        32'h8000_0000, 0); // 30 stray beat
        add(0, 0, 1, 32'h7777_7777,2'b00, 0, 0, 32'h0,          1, 32'h8000_0000, 0, 0, 32'h0,        32'h8000_0000, 0); // 31 still ignored
        add(0, 1, 0, 32'h0,        2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 1, 0, 32'h0,        32'h8000_0000, 0); // 32
        add(0, 0, 1, 32'h0000_0297,2'b00, 0, 0, 32'h0,          0, 32'h8000_0000, 0, 1, 32'h0000_0297,32'h8000_0000, 0); // 33

        foreach (vecs[i]) begin
            rst = vecs[i].rst; arready = vecs[i].arready; rvalid = vecs[i].rvalid;
            rdata = vecs[i].rdata; rresp = vecs[i].rresp; inst_ready = vecs[i].inst_ready;
            npc_valid = vecs[i].npc_valid; npc = vecs[i].npc;
            @(posedge clk);
            #1;
            n_cmp++;
            if (arvalid !== vecs[i].e_arvalid || araddr !== vecs[i].e_araddr ||
                rready !== vecs[i].e_rready || inst_valid !== vecs[i].e_iv ||
                inst !== vecs[i].e_inst || inst_pc !== vecs[i].e_pc || inst_err !== vecs[i].e_err) begin
                n_bad++;
                $display("FAIL row%0d: got av=%0b addr=%h rr=%0b iv=%0b inst=%h pc=%h err=%0b; expected av=%0b addr=%h rr=%0b iv=%0b inst=%h pc=%h err=%0b",
                         i, arvalid, araddr, rready, inst_valid, inst, inst_pc, inst_err,
                         vecs[i].e_arvalid, vecs[i].e_araddr, vecs[i].e_rready, vecs[i].e_iv,
                         vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_err);
            end
        end

        // Back-to-back fetch at best-case latency: jump accepted together with issue,
        // imem always ready, rvalid held high (ignored until the AR handshake).
        rst = 1'b0; inst_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0200;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h00a0_0513; rresp = 2'b00;
        @(posedge clk);
        #1;
        check("jump_arvalid", {31'h0, arvalid}, 32'h1);
        check("jump_araddr", araddr, 32'h8000_0200);
        inst_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;
        cycles = 0;
        while (inst_valid !== 1'b1 && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("fetch_to_issue_cycles", cycles, 32'd2);
        check("b2b_inst", inst, 32'h00a0_0513);
        check("b2b_inst_pc", inst_pc, 32'h8000_0200);
        check("b2b_inst_err", {31'h0, inst_err}, 32'h0);
        rvalid = 1'b0; arready = 1'b0;

`ifndef IFU_PERF_EN
        check("perf_fetch_tied", perf_fetch_cnt, 32'h0);
        check("perf_stall_tied", perf_stall_cnt, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
